// File: rtl/id_ex_stage_pkg.sv
// Shared decode/execute definitions: occupancy states, immediate types, control-word layout.
// Default widths for the ID/EX stage live here as well.
package id_ex_stage_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned CTRL_W_DEF     = 16;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } occ_e;

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmB    = 3'd2,
        ImmJ    = 3'd3,
        ImmS    = 3'd4,
        ImmU    = 3'd5
    } imm_type_e;

    // Control-word field layout (opaque to this stage, consumed by EX/MEM/WB).
    localparam int unsigned CTRL_ALU_OP_LSB   = 0;
    localparam int unsigned CTRL_ALU_OP_W     = 5;
    localparam int unsigned CTRL_IMM_TYPE_LSB = 5;
    localparam int unsigned CTRL_IMM_TYPE_W   = 3;
    localparam int unsigned CTRL_MEM_RD_BIT   = 8;
    localparam int unsigned CTRL_MEM_WR_BIT   = 9;
    localparam int unsigned CTRL_WB_EN_BIT    = 10;

    function automatic logic ctrl_wb_en(input logic [CTRL_W_DEF-1:0] ctrl);
        return ctrl[CTRL_WB_EN_BIT];
    endfunction

endpackage

// File: rtl/id_ex_stage_slot.sv
// One ID/EX bundle register: load enable, async clear, output forced to zero when not valid.
module id_ex_stage_slot
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = i_valid ? r_data : '0;

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline stage with a 2-entry skid buffer and synchronous flush.
// Define ID_EX_PERF_CNT_EN to build the stall/bubble performance counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned CTRL_W     = CTRL_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_W-1:0]     i_in_pc,
    input  logic [DATA_W-1:0]     i_in_rs1_data,
    input  logic [DATA_W-1:0]     i_in_rs2_data,
    input  logic [DATA_W-1:0]     i_in_imm,
    input  logic [REG_ADDR_W-1:0] i_in_rd,
    input  logic [CTRL_W-1:0]     i_in_ctrl,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_W-1:0]     o_out_pc,
    output logic [DATA_W-1:0]     o_out_rs1_data,
    output logic [DATA_W-1:0]     o_out_rs2_data,
    output logic [DATA_W-1:0]     o_out_imm,
    output logic [REG_ADDR_W-1:0] o_out_rd,
    output logic [CTRL_W-1:0]     o_out_ctrl,
    output logic [31:0]           o_perf_stall_cnt,
    output logic [31:0]           o_perf_bubble_cnt
);

    localparam int unsigned BUN_W = 4 * DATA_W + REG_ADDR_W + CTRL_W;

    occ_e             r_state;
    occ_e             w_state_d;
    logic             r_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_valid;
    logic             w_skid_valid;
    logic             w_main_load;
    logic             w_main_from_skid;
    logic             w_skid_load;
    logic [BUN_W-1:0] w_in_bun;
    logic [BUN_W-1:0] w_main_d;
    logic [BUN_W-1:0] w_main_q;
    logic [BUN_W-1:0] w_skid_q;

    assign w_main_valid = (r_state != StEmpty);
    assign w_skid_valid = (r_state == StTwo);
    assign w_in_fire    = i_in_valid & r_in_ready;
    assign w_out_fire   = w_main_valid & i_out_ready;
    assign w_in_bun     = {i_in_pc, i_in_rs1_data, i_in_rs2_data, i_in_imm, i_in_rd, i_in_ctrl};

    always_comb begin
        w_state_d        = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (i_flush) begin
            // Redirect wins: held entries and any same-cycle input are dropped.
            w_state_d = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        w_state_d   = StOne;
                        w_main_load = 1'b1;
                    end
                end
                StOne: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_d   = StTwo;
                        w_skid_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (w_out_fire) begin
                        w_state_d        = StOne;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d != StTwo);
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_bun;

    id_ex_stage_slot #(
        .W (BUN_W)
    ) u_main (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_main_load),
        .i_data  (w_main_d),
        .i_valid (w_main_valid),
        .o_data  (w_main_q)
    );

    id_ex_stage_slot #(
        .W (BUN_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_data  (w_in_bun),
        .i_valid (w_skid_valid),
        .o_data  (w_skid_q)
    );

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = w_main_valid;
    assign {o_out_pc, o_out_rs1_data, o_out_rs2_data, o_out_imm, o_out_rd, o_out_ctrl} = w_main_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_main_valid && !i_out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!w_main_valid && i_out_ready) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign o_perf_stall_cnt  = r_stall_cnt;
    assign o_perf_bubble_cnt = r_bubble_cnt;
`else
    assign o_perf_stall_cnt  = '0;
    assign o_perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs a queue model.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } bun_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    bun_t        in_b;
    logic [31:0] o_pc, o_rs1, o_rs2, o_imm;
    logic [4:0]  o_rd;
    logic [15:0] o_ctrl;
    logic [31:0] stall_cnt, bubble_cnt;

    int          checks   = 0;
    int          failures = 0;
    bun_t        q[$];
    int unsigned m_stall  = 0;
    int unsigned m_bubble = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_flush           (flush),
        .i_in_valid        (in_valid),
        .o_in_ready        (in_ready),
        .i_in_pc           (in_b.pc),
        .i_in_rs1_data     (in_b.rs1),
        .i_in_rs2_data     (in_b.rs2),
        .i_in_imm          (in_b.imm),
        .i_in_rd           (in_b.rd),
        .i_in_ctrl         (in_b.ctrl),
        .o_out_valid       (out_valid),
        .i_out_ready       (out_ready),
        .o_out_pc          (o_pc),
        .o_out_rs1_data    (o_rs1),
        .o_out_rs2_data    (o_rs2),
        .o_out_imm         (o_imm),
        .o_out_rd          (o_rd),
        .o_out_ctrl        (o_ctrl),
        .o_perf_stall_cnt  (stall_cnt),
        .o_perf_bubble_cnt (bubble_cnt)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bun_t rand_bun();
        bun_t b;
        b.pc   = $urandom;
        b.rs1  = $urandom;
        b.rs2  = $urandom;
        b.imm  = $urandom;
        b.rd   = 5'($urandom);
        b.ctrl = 16'($urandom);
        return b;
    endfunction

    task automatic check_model(input string tag);
        bun_t exp_b;
        bun_t got_b;
        exp_b = '0;
        if (q.size() > 0) exp_b = q[0];
        got_b = {o_pc, o_rs1, o_rs2, o_imm, o_rd, o_ctrl};
        chk({tag, ".out_valid"}, out_valid, q.size() > 0);
        chk({tag, ".in_ready"}, in_ready, q.size() < 2);
        chk({tag, ".bundle"}, got_b, exp_b);
`ifdef ID_EX_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
        chk({tag, ".bubble_cnt"}, bubble_cnt, m_bubble);
`else
        chk({tag, ".stall_cnt"}, stall_cnt, 0);
        chk({tag, ".bubble_cnt"}, bubble_cnt, 0);
`endif
    endtask

    // Called at posedge+1: drive inputs, advance one clock, update model, compare.
    task automatic cycle(input logic v, input logic r, input logic f, input bun_t b,
                         input string tag);
        bit inf;
        bit outf;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_b      = b;
        inf  = v && (q.size() < 2);
        outf = (q.size() > 0) && r;
        if (q.size() > 0 && !r) m_stall++;
        if (q.size() == 0 && r) m_bubble++;
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(b);
        end
        check_model(tag);
    endtask

    function automatic bun_t bun_pc(input logic [31:0] pc);
        bun_t b;
        b    = rand_bun();
        b.pc = pc;
        return b;
    endfunction

    initial begin
        bun_t b;
        int   n;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;

        // 1: single bundle, then bubble
        b     = bun_pc(32'h100);
        b.imm = 32'hFFFF_F800;
        cycle(1'b1, 1'b1, 1'b0, b, "t1_push");
        chk("t1_pc", o_pc, 32'h100);
        chk("t1_imm", o_imm, 32'hFFFF_F800);
        cycle(1'b0, 1'b1, 1'b0, '0, "t1_bubble");
        chk("t1_bub_valid", out_valid, 1'b0);
        chk("t1_bub_rd", o_rd, 5'd0);
        chk("t1_bub_ctrl", o_ctrl, 16'd0);

        // 2: backpressure fills skid, held input waits, FIFO order on release
        cycle(1'b1, 1'b0, 1'b0, bun_pc(32'h100), "t2_p0");
        cycle(1'b1, 1'b0, 1'b0, bun_pc(32'h104), "t2_p1");
        chk("t2_full_ready", in_ready, 1'b0);
        b = bun_pc(32'h108);
        cycle(1'b1, 1'b0, 1'b0, b, "t2_hold");
        chk("t2_hold_pc", o_pc, 32'h100);
        cycle(1'b1, 1'b1, 1'b0, b, "t2_r0");
        chk("t2_r0_pc", o_pc, 32'h104);
        cycle(1'b1, 1'b1, 1'b0, b, "t2_r1");
        chk("t2_r1_pc", o_pc, 32'h108);
        cycle(1'b0, 1'b1, 1'b0, '0, "t2_drain");
        chk("t2_empty", out_valid, 1'b0);

        // 3: streaming, one output per cycle
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, rand_bun(), "t3_stream");
            if (out_valid === 1'b1 && in_ready === 1'b1) n++;
        end
        chk("t3_count", n, 20);
        cycle(1'b0, 1'b1, 1'b0, '0, "t3_drain");

        // 4: flush from TWO with a valid input, then flush from ONE with an accepted input
        cycle(1'b1, 1'b0, 1'b0, rand_bun(), "t4_f0");
        cycle(1'b1, 1'b0, 1'b0, rand_bun(), "t4_f1");
        cycle(1'b1, 1'b0, 1'b1, bun_pc(32'h200), "t4_flush2");
        chk("t4_valid", out_valid, 1'b0);
        chk("t4_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0, "t4_after");
            chk("t4_no200", out_valid, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, rand_bun(), "t4_one");
        cycle(1'b1, 1'b1, 1'b1, bun_pc(32'h200), "t4_flush1");
        chk("t4_one_valid", out_valid, 1'b0);

        // 5: asynchronous reset while TWO
        cycle(1'b1, 1'b0, 1'b0, rand_bun(), "t5_f0");
        cycle(1'b1, 1'b0, 1'b0, rand_bun(), "t5_f1");
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        m_stall  = 0;
        m_bubble = 0;
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_ready", in_ready, 1'b1);
        check_model("t5_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_model("t5_release");

        // 6: perf counters, 3 stalled + 2 idle-ready cycles
        cycle(1'b1, 1'b0, 1'b0, rand_bun(), "t6_push");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, "t6_stall");
        cycle(1'b0, 1'b1, 1'b0, '0, "t6_pop");
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, '0, "t6_idle");
`ifdef ID_EX_PERF_CNT_EN
        chk("t6_stall", stall_cnt, 32'd3);
        chk("t6_bubble", bubble_cnt, 32'd2);
`else
        chk("t6_stall", stall_cnt, 32'd0);
        chk("t6_bubble", bubble_cnt, 32'd0);
`endif

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
                  rand_bun(), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
